// File: rtl/instr_encoder.sv
// Purpose : assembles MIPS machine words (addu/subu/ori/lw/sw/beq/lui/j/jal/jr/nop)
//           from symbolic fields and writes them sequentially into instruction memory.
// Latency : handshake at edge N -> im_we high during cycle N+1 -> count updated at edge N+1.
// Backpr. : in_ready is high only in IDLE, so at most one word is accepted every 2 cycles.
//           in_ready stays low when the memory is full or after an illegal kind, until clr/reset.
// Ports   : clk, reset (async, active-low), clr (sync restart)
//           in_valid/in_ready handshake; in_kind/in_rs/in_rt/in_rd/in_imm/in_target request fields
//           im_we/im_addr/im_wdata IM write port
//           count (words written), pc_next (BASE_PC + 4*count), full, err (sticky)
module instr_encoder #(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] BASE_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic [31:0]       pc_next,
  output logic              full,
  output logic              err
);

  localparam logic [3:0] K_NOP  = 4'd0;
  localparam logic [3:0] K_ADDU = 4'd1;
  localparam logic [3:0] K_SUBU = 4'd2;
  localparam logic [3:0] K_ORI  = 4'd3;
  localparam logic [3:0] K_LW   = 4'd4;
  localparam logic [3:0] K_SW   = 4'd5;
  localparam logic [3:0] K_BEQ  = 4'd6;
  localparam logic [3:0] K_LUI  = 4'd7;
  localparam logic [3:0] K_J    = 4'd8;
  localparam logic [3:0] K_JAL  = 4'd9;
  localparam logic [3:0] K_JR   = 4'd10;

  // count value just before the final write (DEPTH-1)
  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         enc;
  logic                legal;
  logic                accept;
  logic [ADDR_W-1:0]   ptr;

  // The write pointer is the low bits of count; it wraps to 0 on the final
  // write while count saturates at DEPTH.
  assign ptr    = count[ADDR_W-1:0];
  assign legal  = (in_kind <= K_JR);
  // A request arriving together with clr is dropped.
  assign accept = in_valid & in_ready & ~clr;

  assign pc_next = BASE_PC + {{(30-ADDR_W-1){1'b0}}, count, 2'b00};

  // Field packing; fields a kind does not use are forced to zero.
  always_comb begin
    enc = 32'd0;
    case (in_kind)
      K_NOP:  enc = 32'd0;
      K_ADDU: enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100001};
      K_SUBU: enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100011};
      K_ORI:  enc = {6'b001101, in_rs, in_rt, in_imm};
      K_LW:   enc = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:   enc = {6'b101011, in_rs, in_rt, in_imm};
      K_BEQ:  enc = {6'b000100, in_rs, in_rt, in_imm};
      K_LUI:  enc = {6'b001111, 5'd0, in_rt, in_imm};
      K_J:    enc = {6'b000010, in_target};
      K_JAL:  enc = {6'b000011, in_target};
      K_JR:   enc = {6'b000000, in_rs, 15'd0, 6'b001000};
      default: enc = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // im_we decodes straight from the state register, so an asynchronous reset
  // during WRITE removes the strobe immediately.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == S_IDLE);
    im_we     = (state == S_WRITE);
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt = legal ? S_WRITE : S_ERR;
        end
      end
      S_WRITE: begin
        state_nxt = (count == LAST_CNT) ? S_FULL : S_IDLE;
      end
      S_FULL:  state_nxt = S_FULL;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
    if (clr) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      im_addr  <= '0;
      im_wdata <= 32'd0;
      full     <= 1'b0;
      err      <= 1'b0;
    end else if (clr) begin
      count <= '0;
      full  <= 1'b0;
      err   <= 1'b0;
    end else begin
      // Address and word are captured at the handshake and then held, so
      // they stay stable through WRITE and afterwards.
      if (accept && legal) begin
        im_addr  <= ptr;
        im_wdata <= enc;
      end
      if (accept && !legal) begin
        err <= 1'b1;
      end
      if (state == S_WRITE) begin
        count <= count + 1'b1;
        if (count == LAST_CNT) begin
          full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int          AW    = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  localparam longint F_OP = 64'd67108864;  // 2**26
  localparam longint F_RS = 64'd2097152;   // 2**21
  localparam longint F_RT = 64'd65536;     // 2**16
  localparam longint F_RD = 64'd2048;      // 2**11

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_kind;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   count;
  logic [31:0]   pc_next;
  logic          full;
  logic          err;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_PC(BASE)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .count(count), .pc_next(pc_next), .full(full), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the field layout, using plain arithmetic.
  function automatic logic [31:0] ref_enc(input int kind, input int rs, input int rt,
                                          input int rd, input int imm, input int tgt);
    longint w;
    case (kind)
      1:  w = rs * F_RS + rt * F_RT + rd * F_RD + 33;
      2:  w = rs * F_RS + rt * F_RT + rd * F_RD + 35;
      3:  w = 13 * F_OP + rs * F_RS + rt * F_RT + imm;
      4:  w = 35 * F_OP + rs * F_RS + rt * F_RT + imm;
      5:  w = 43 * F_OP + rs * F_RS + rt * F_RT + imm;
      6:  w = 4 * F_OP + rs * F_RS + rt * F_RT + imm;
      7:  w = 15 * F_OP + rt * F_RT + imm;
      8:  w = 2 * F_OP + tgt;
      9:  w = 3 * F_OP + tgt;
      10: w = rs * F_RS + 8;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  task automatic scramble();
    in_kind   = 4'($urandom_range(0, 15));
    in_rs     = 5'($urandom);
    in_rt     = 5'($urandom);
    in_rd     = 5'($urandom);
    in_imm    = 16'($urandom);
    in_target = 26'($urandom);
  endtask

  // One request: wait for in_ready, handshake, check the write cycle and the
  // following cycle. Called at posedge+1.
  task automatic send(input int kind, input int rs, input int rt, input int rd,
                      input int imm, input int tgt, input logic [31:0] exp_w,
                      input string tag);
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_rdy_wait"}, in_ready, 1);
    in_kind   = 4'(kind);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_imm    = 16'(imm);
    in_target = 26'(tgt);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    chk({tag, "_we"},    im_we, 1);
    chk({tag, "_addr"},  im_addr, exp_cnt % DEPTH);
    chk({tag, "_wdata"}, im_wdata, exp_w);
    chk({tag, "_rdy_lo"}, in_ready, 0);
    @(posedge clk); #1;
    exp_cnt++;
    chk({tag, "_we_off"}, im_we, 0);
    chk({tag, "_count"},  count, exp_cnt);
    chk({tag, "_pc"},     pc_next, BASE + 4 * exp_cnt);
    chk({tag, "_full"},   full, (exp_cnt == DEPTH));
    chk({tag, "_rdy_hi"}, in_ready, (exp_cnt != DEPTH));
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_cnt = 0;
    chk({tag, "_count"}, count, 0);
    chk({tag, "_rdy"},   in_ready, 1);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_full"},  full, 0);
    chk({tag, "_pc"},    pc_next, BASE);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    im_we, 0);
    chk({tag, "_addr"},  im_addr, 0);
    chk({tag, "_wdata"}, im_wdata, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_full"},  full, 0);
    chk({tag, "_rdy"},   in_ready, 1);
    chk({tag, "_pc"},    pc_next, BASE);
  endtask

  logic [AW-1:0] addrs[$];

  initial begin
    reset    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    scramble();

    // Reset values
    #3;
    chk_reset_vals("rst");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // ADDU
    send(1, 1, 2, 3, 0, 0, 32'h0022_1821, "addu");
    do_clr("clr1");

    // ORI then LUI (rs masked)
    send(3, 0, 8, 0, 16'h1234, 0, 32'h3408_1234, "ori");
    send(7, 5, 1, 0, 16'hABCD, 0, 32'h3C01_ABCD, "lui");
    do_clr("clr2");

    // JAL, JR, SW
    send(9, 0, 0, 0, 0, 26'h0000C03, 32'h0C00_0C03, "jal");
    send(10, 31, 0, 7, 0, 0, 32'h03E0_0008, "jr");
    send(5, 0, 2, 0, 4, 0, 32'hAC02_0004, "sw");
    do_clr("clr3");

    // Fill with in_valid held high: only DEPTH writes may happen
    addrs.delete();
    in_kind = 4'd1; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6;
    in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (im_we) addrs.push_back(im_addr);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("fill_writes", addrs.size(), DEPTH);
    for (int i = 0; i < addrs.size() && i < DEPTH; i++) begin
      chk("fill_addr", addrs[i], i);
    end
    chk("fill_full",  full, 1);
    chk("fill_count", count, DEPTH);
    chk("fill_rdy",   in_ready, 0);
    chk("fill_pc",    pc_next, BASE + 4 * DEPTH);
    do_clr("clr4");

    // Illegal kind: sticky err, later requests ignored
    in_kind = 4'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ill_we",  im_we, 0);
    chk("ill_err", err, 1);
    chk("ill_rdy", in_ready, 0);
    in_kind = 4'd1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("ill_ign_we", im_we, 0);
    end
    in_valid = 1'b0;
    chk("ill_count", count, 0);
    chk("ill_sticky", err, 1);
    do_clr("clr5");
    send(1, 1, 2, 3, 0, 0, 32'h0022_1821, "post_ill");

    // Reset asserted during WRITE
    in_kind = 4'd2; in_rs = 5'd9; in_rt = 5'd10; in_rd = 5'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rw_we",   im_we, 1);
    chk("rw_addr", im_addr, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("rw");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 0;
    send(8, 0, 0, 0, 0, 26'h3FF_FFFF, 32'h0BFF_FFFF, "post_rst");

    // Randomized requests against the reference model
    for (int it = 0; it < 40; it++) begin
      int k, rs, rt, rd, imm, tgt;
      if (exp_cnt == DEPTH) begin
        chk("rnd_full", full, 1);
        do_clr("rnd_clr");
      end
      k   = $urandom_range(0, 10);
      rs  = $urandom_range(0, 31);
      rt  = $urandom_range(0, 31);
      rd  = $urandom_range(0, 31);
      imm = $urandom_range(0, 65535);
      tgt = $urandom_range(0, (1 << 26) - 1);
      send(k, rs, rt, rd, imm, tgt, ref_enc(k, rs, rt, rd, imm, tgt), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
